// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default bit timing.
// Reused by uart_rx today and a future uart_tx.
package uart_pkg;

  localparam int UART_CLKS_PER_BIT = 868;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP,
    BREAK  = ST_BREAK
  } uart_state_t;

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer for a single asynchronous input.
// Both flops reset to RESET_VAL so the output starts in a known idle level.
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic nRst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: one-cycle `out` strobe per good byte, `err` strobe per bad frame.
// Define UART_RX_PARITY_EN to expect one even-parity bit between bit 7 and the stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       out,
  output logic       err,
  output logic       busy
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_s;
  uart_state_t      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift, shift_n;
  logic [7:0]       data_n;
  logic             out_n, err_n;
`ifdef UART_RX_PARITY_EN
  logic             par_bad, par_bad_n;
`endif

  sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk  (clk),
    .nRst (nRst),
    .d    (rx),
    .q    (rx_s)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      data_out <= 8'h00;
      out      <= 1'b0;
      err      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad  <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_idx_n;
      shift    <= shift_n;
      data_out <= data_n;
      out      <= out_n;
      err      <= err_n;
`ifdef UART_RX_PARITY_EN
      par_bad  <= par_bad_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    data_n    = data_out;
    out_n     = 1'b0;
    err_n     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_n = par_bad;
`endif

    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = START;
      end

      // Re-check the start bit mid-bit so short glitches are rejected.
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_n = '0;
          if (!rx_s) begin
            state_n   = DATA;
            bit_idx_n = 3'd0;
          end else begin
            state_n = IDLE;
          end
        end
      end

      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n     = '0;
          shift_n   = {rx_s, shift[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == BIT_LAST) begin
          cnt_n     = '0;
          par_bad_n = (^shift) ^ rx_s;
          state_n   = STOP;
        end
      end
`endif

      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            state_n = IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bad) begin
              err_n = 1'b1;
            end else begin
              out_n  = 1'b1;
              data_n = shift;
            end
`else
            out_n  = 1'b1;
            data_n = shift;
`endif
          end else begin
            err_n   = 1'b1;
            state_n = BREAK;
          end
        end
      end

      // Hold off until the line releases so a stuck-low line is not a new start bit.
      BREAK: begin
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end

      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 16 clocks per bit.
// Covers UART_RX_PARITY_EN builds when the macro is defined for both files.
module tb_uart_rx;

  localparam int C = 16;
`ifdef UART_RX_PARITY_EN
  localparam int STOP_OFS = 8 + 10 * C;
  localparam int FRAME    = 11 * C;
`else
  localparam int STOP_OFS = 8 + 9 * C;
  localparam int FRAME    = 10 * C;
`endif

  logic       clk;
  logic       nRst;
  logic       rx;
  logic [7:0] data_out;
  logic       out;
  logic       err;
  logic       busy;

  int compared;
  int mismatched;
  int cycle;
  int outCount;
  int errCount;
  int bothCount;
  int startCycle;
  int lastOutCycle;
  logic prevBusy;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk      (clk),
    .nRst     (nRst),
    .rx       (rx),
    .data_out (data_out),
    .out      (out),
    .err      (err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Strobe monitor: counts pulses and timestamps frame starts and good bytes.
  initial begin
    outCount = 0; errCount = 0; bothCount = 0;
    startCycle = 0; lastOutCycle = 0; prevBusy = 1'b0;
  end
  always @(negedge clk) begin
    if (out) begin
      outCount++;
      lastOutCycle = cycle;
    end
    if (err) errCount++;
    if (out && err) bothCount++;
    if (busy && !prevBusy) startCycle = cycle;
    prevBusy = busy;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitBit();
    repeat (C) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic stopBit, input logic parFlip);
    logic parBit;
    parBit = (^d) ^ parFlip;
    rx = 1'b0;
    waitBit();
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      waitBit();
    end
`ifdef UART_RX_PARITY_EN
    rx = parBit;
    waitBit();
`endif
    rx = stopBit;
    waitBit();
  endtask

  initial begin
    int o0;
    int e0;
    int firstOut;
    logic [7:0] pat;

    compared = 0;
    mismatched = 0;
    nRst = 1'b0;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 nRst = 1'b1;
    @(negedge clk);
    checkOutput("reset_data", 32'(data_out), 32'h00);
    checkOutput("reset_out", 32'(out), 32'h0);
    checkOutput("reset_err", 32'(err), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    repeat (5) @(posedge clk);
    #1;

    $display("[TB] clean frame 0x5A");
    o0 = outCount; e0 = errCount;
    applyStimulus(8'h5A, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("clean_out_pulses", 32'(outCount - o0), 32'd1);
    checkOutput("clean_err_pulses", 32'(errCount - e0), 32'd0);
    checkOutput("clean_data", 32'(data_out), 32'h5A);
    checkOutput("clean_timing", 32'(lastOutCycle - startCycle), 32'(STOP_OFS));

    $display("[TB] start-bit glitch");
    o0 = outCount; e0 = errCount;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    checkOutput("glitch_busy_e0p7", 32'(busy), 32'h1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("glitch_busy_e0p8", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
    repeat (2 * C) @(posedge clk);
    #1;
    checkOutput("glitch_out_pulses", 32'(outCount - o0), 32'd0);
    checkOutput("glitch_err_pulses", 32'(errCount - e0), 32'd0);

    $display("[TB] framing error 0x33");
    o0 = outCount; e0 = errCount;
    applyStimulus(8'h33, 1'b0, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    checkOutput("ferr_err_pulses", 32'(errCount - e0), 32'd1);
    checkOutput("ferr_out_pulses", 32'(outCount - o0), 32'd0);
    checkOutput("ferr_data_held", 32'(data_out), 32'h5A);
    checkOutput("ferr_busy_held", 32'(busy), 32'h1);
    rx = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("ferr_busy_release", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
    repeat (C) @(posedge clk);
    #1;
    o0 = outCount;
    applyStimulus(8'h11, 1'b1, 1'b0);
    checkOutput("ferr_next_out", 32'(outCount - o0), 32'd1);
    checkOutput("ferr_next_data", 32'(data_out), 32'h11);
    checkOutput("ferr_err_single", 32'(errCount - e0), 32'd1);

    $display("[TB] back-to-back 0x00 then 0xFF");
    o0 = outCount;
    applyStimulus(8'h00, 1'b1, 1'b0);
    checkOutput("b2b_first_data", 32'(data_out), 32'h00);
    firstOut = lastOutCycle;
    applyStimulus(8'hFF, 1'b1, 1'b0);
    checkOutput("b2b_second_data", 32'(data_out), 32'hFF);
    checkOutput("b2b_spacing", 32'(lastOutCycle - firstOut), 32'(FRAME));
    checkOutput("b2b_out_pulses", 32'(outCount - o0), 32'd2);

    $display("[TB] reset during data bit 4");
    o0 = outCount; e0 = errCount;
    pat = 8'hA5;
    rx = 1'b0;
    waitBit();
    for (int i = 0; i < 4; i++) begin
      rx = pat[i];
      waitBit();
    end
    rx = pat[4];
    repeat (8) @(posedge clk);
    #1;
    checkOutput("rst_busy_before", 32'(busy), 32'h1);
    rx = 1'b1;
    nRst = 1'b0;
    #1;
    checkOutput("rst_data", 32'(data_out), 32'h00);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_out", 32'(out), 32'h0);
    @(posedge clk);
    #1 nRst = 1'b1;
    repeat (2 * C) @(posedge clk);
    #1;
    checkOutput("rst_no_out", 32'(outCount - o0), 32'd0);
    checkOutput("rst_no_err", 32'(errCount - e0), 32'd0);
    applyStimulus(8'hA5, 1'b1, 1'b0);
    checkOutput("rst_next_data", 32'(data_out), 32'hA5);
    checkOutput("rst_next_out", 32'(outCount - o0), 32'd1);

`ifdef UART_RX_PARITY_EN
    $display("[TB] parity checks on 0x07");
    o0 = outCount; e0 = errCount;
    applyStimulus(8'h07, 1'b1, 1'b0);
    checkOutput("par_good_out", 32'(outCount - o0), 32'd1);
    checkOutput("par_good_data", 32'(data_out), 32'h07);
    checkOutput("par_good_err", 32'(errCount - e0), 32'd0);
    o0 = outCount; e0 = errCount;
    applyStimulus(8'h07, 1'b1, 1'b1);
    checkOutput("par_bad_err", 32'(errCount - e0), 32'd1);
    checkOutput("par_bad_out", 32'(outCount - o0), 32'd0);
    checkOutput("par_bad_busy", 32'(busy), 32'h0);
`endif

    checkOutput("no_overlap", 32'(bothCount), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive front-end of the FPGA host link. Recovers 8N1 frames from the asynchronous `rx` pin, converts them to parallel bytes, and presents each byte to the controller as `data_out` with a one-cycle `out` strobe. The strobe connects to the controller's `in`, and `data_out` connects to its `data_in`. Bad frames raise a one-cycle `err` strobe instead and never produce a byte.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per bit (100 MHz / 115200 baud); must be ≥ 4.
- `clk`  in  1  system clock; all logic on posedge.
- `nRst`  in  1  reset, asynchronous, active-low; one clock.
- `rx`  in  1  raw serial line; idles high; asynchronous to `clk`.
- `data_out`  out  8  last good byte, LSB received first; held until the next good frame.
- `out`  out  1  one-cycle strobe: `data_out` updated this cycle.
- `err`  out  1  one-cycle strobe: framing error (or parity error, see Configuration).
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer; both flops reset to 1. All decisions use the synchronized value `rx_s`.
- Let C = `CLKS_PER_BIT` and H = C/2 (integer division).
- The bit-period counter is sized for C−1 and cleared on every state change. The bit index is 3 bits.
- States: IDLE, START, DATA, (PARITY), STOP, BREAK.
  - **IDLE:** when `rx_s`=0, go to START and clear the counter.
  - **START:** at counter = H−1, sample `rx_s`.
    - If `rx_s`=0, go to DATA with bit index 0.
    - If `rx_s`=1, it was a glitch: return to IDLE with no strobe.
  - **DATA:** every C cycles, shift `rx_s` into bit[7] of the shift register (right shift, so LSB arrives first).
    - After bit index 7, go to STOP, or to PARITY when the parity feature is enabled.
  - **STOP:** after C cycles, sample `rx_s`.
    - If 1: load `data_out` from the shift register, pulse `out`, go to IDLE.
    - If 0: pulse `err`, leave `data_out` unchanged, go to BREAK.
  - **BREAK:** wait until `rx_s`=1, then go to IDLE. This stops a held-low line from being re-detected as a start bit.
- `out` and `err` are never high in the same cycle. Each is high for exactly one cycle per frame.
- Reset values: `data_out`=8'h00, `out`=0, `err`=0, `busy`=0, state IDLE. Reset mid-frame discards the partial byte.

## Timing
- Let E0 be the clock edge at which the FSM leaves IDLE; this is 2–3 edges after the pin falls.
- Sample edges:
  - start bit: E0+H
  - data bit k (k = 0..7): E0+H+(k+1)·C
  - stop bit: E0+H+9C, or E0+H+10C with parity enabled.
- `out`/`err` are registered on the stop-sample edge and are high for the following cycle.
- The FSM is back in IDLE H cycles before the nominal end of the stop bit. Back-to-back frames with a one-bit stop are therefore accepted.
- The controller's `in` sees `out` directly; there is no backpressure. A new byte overwrites `data_out` at most once per frame time.

## Configuration
- **`UART_RX_PARITY_EN` defined:** the PARITY state is compiled in and expects one even-parity bit after bit 7, sampled C cycles after bit 7.
  - If the XOR of the data bits and the parity bit is 1, `err` pulses at the stop sample, `out` stays low, and `data_out` is unchanged. The stop bit is still checked; its error path goes to BREAK.
- **Undefined:** 8N1 only; the PARITY state and parity logic are absent.

## Structure
- Shared package `uart_pkg`: state encoding localparams (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, BREAK=5) and the default `CLKS_PER_BIT`. A future `uart_tx` reuses them.
- One sub-module, `sync2`: a 2-flop synchronizer with a reset-value parameter, instantiated with reset value 1.

## Test plan
All scenarios use `CLKS_PER_BIT`=16 (H=8).
- **Clean frame 0x5A:** `out` high for one cycle at E0+152+1, `data_out`=8'h5A, `err` never asserted.
- **Glitch:** `rx` low for 4 cycles, then high → no `out`, no `err`, `busy` back low by E0+8.
- **Framing error:** frame 0x33 with stop bit 0 and line held low for 40 more cycles → one `err` pulse, `data_out` stays 8'h5A, `busy` stays high until the line returns high. A following 0x11 frame yields `out` with `data_out`=8'h11.
- **Back-to-back:** 0x00 then 0xFF, each with a single stop bit → two `out` pulses 160 cycles apart, with `data_out` 8'h00 then 8'hFF.
- **Reset mid-frame:** `nRst` pulsed low during data bit 4 → `data_out`=8'h00, `busy`=0, no strobe. The next 0xA5 frame is received correctly.
- **Parity (`UART_RX_PARITY_EN`):**
  - 0x07 with parity bit 1 → `out`, `data_out`=8'h07.
  - 0x07 with parity bit 0 → `err`, no `out`.
